// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline stage with a two-entry skid buffer (main + skid).
// Latency: 1 cycle from in-fire to out_* when the stage is empty or draining in the same cycle.
// Backpressure: in_ready = !skid_valid, registered state only; at most one extra beat absorbed on a stall.
module pipe_skid_stage #(
  parameter int DATA_WIDTH  = 128,
  parameter int CTRL_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [CTRL_WIDTH-1:0]  in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [CTRL_WIDTH-1:0]  out_ctrl,
  output logic [1:0]             occupancy,
  output logic [COUNT_WIDTH-1:0] bubble_count,
  input  logic                   count_clear
);

  // Head entry drives the outputs; skid entry catches the beat accepted while the head stalls.
  logic                  main_valid;
  logic [DATA_WIDTH-1:0] main_data;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [CTRL_WIDTH-1:0] skid_ctrl;

  logic in_fire;
  logic out_fire;

  // Handshake and status decode; all derived from registered state plus the live handshakes.
  always_comb begin
    in_ready  = !skid_valid;
    out_valid = main_valid;
    out_data  = main_data;
    out_ctrl  = main_ctrl;
    occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
    in_fire   = in_valid && !skid_valid;
    out_fire  = main_valid && out_ready;
  end

  // Entry storage: reset beats flush beats normal fill/drain; ctrl is zeroed whenever the head empties.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else if (skid_valid) begin
      // Full: only a downstream transfer frees a slot, and the skid moves up to the head.
      if (out_fire) begin
        main_data  <= skid_data;
        main_ctrl  <= skid_ctrl;
        skid_valid <= 1'b0;
      end
    end else if (main_valid) begin
      if (in_fire && out_fire) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (in_fire) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
        skid_ctrl  <= in_ctrl;
      end else if (out_fire) begin
        // Drain keeps the last payload visible but never leaves stale control asserted.
        main_valid <= 1'b0;
        main_ctrl  <= '0;
      end
    end else if (in_fire) begin
      main_valid <= 1'b1;
      main_data  <= in_data;
      main_ctrl  <= in_ctrl;
    end
  end

  // Saturating count of cycles where downstream was ready but nothing was offered; flush leaves it alone.
  always_ff @(posedge clock) begin
    if (reset || count_clear) begin
      bubble_count <= '0;
    end else if (out_ready && !main_valid && (bubble_count != {COUNT_WIDTH{1'b1}})) begin
      bubble_count <= bubble_count + COUNT_WIDTH'(1);
    end
  end

endmodule
